inverse_kinematics_omni: RTL and testbench
==========================================

INVERSE_KINEMATICS_OMNI -- requirements
Module: inverse_kinematics_omni

Interface
REQ-001 Parameter: K_SQRT3_2, default 28378, sqrt(3)/2 in unsigned Q1.15.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 Vx, Vy  in  16 each  signed body-frame linear velocity.
REQ-006 omega  in  16  signed body angular rate.
REQ-007 r  in  16  unsigned wheel radius.
REQ-008 R  in  16  unsigned centre-to-wheel distance.
REQ-009 v1, v2, v3  out  16 each  signed wheel rates; registered; updated only at done.
REQ-010 done  out  1  one-cycle pulse; results valid.
REQ-011 busy  out  1  high from the edge that accepts start until the cycle after done.
REQ-012 div_zero  out  1  set when the last job had r==0; held until the next done or reset.
REQ-013 ovf  out  1  set when any wheel result of the last job saturated; held like div_zero.

Function
REQ-014 On start in IDLE, the block latches Vx, Vy, omega, r and R; later input changes do not affect the job.
REQ-015 States: IDLE -> MUL_R (1 cycle) -> MUL_S (1) -> SUM (1) -> DIV (3 x 34 cycles) -> DONE (1) -> IDLE.
REQ-016 MUL_R: Rw = R * omega, 32-bit signed.
REQ-017 MUL_S: sx = (K_SQRT3_2 * Vx) >>> 15 (arithmetic shift, floor); hy = Vy >>> 1 (floor).
REQ-018 SUM: u1 = Vy + Rw; u2 = -sx - hy + Rw; u3 = sx - hy + Rw; all 34-bit signed, no internal overflow.
REQ-019 DIV: one shared serial restoring divider computes |u_i| / r over 34 cycles per wheel, in order wheel 1, 2, 3. The quotient is truncated toward zero, and the sign of u_i is reapplied.
REQ-020 The block uses exactly one multiplier, shared between MUL_R and MUL_S.
REQ-021 Latency: start is accepted at edge E. done is high, and v1..v3, div_zero and ovf update, from edge E+106. done is low again, and busy low, from edge E+107.
REQ-022 start while busy is ignored; no queuing. start held high re-triggers in the first IDLE cycle.
REQ-023 For r==0 the divider is bypassed: wheel i = +32767 if u_i>0, -32768 if u_i<0, 0 if u_i==0. div_zero=1; latency is unchanged.
REQ-024 No other arithmetic condition stalls or aborts the job.

Reset
REQ-025 While rst is high: state=IDLE; v1, v2, v3 = 0; done, busy, div_zero, ovf = 0; all internal registers cleared.
REQ-026 rst during any non-IDLE state abandons the job; outputs do not change after release; the next start begins a fresh job.

Configuration
REQ-027 Macro IK_SATURATE_EN defined: any quotient outside [-32768, 32767] is clamped to the nearest bound, and ovf is set.
REQ-028 IK_SATURATE_EN undefined: the output is the low 16 bits of the signed quotient (two's-complement wrap); ovf is tied 0. The r==0 behaviour is unchanged.

Verification
REQ-029 Pure rotation: Vx=0, Vy=0, omega=10, R=200, r=100 -> v1=v2=v3=20; done at E+106; div_zero=0, ovf=0.
REQ-030 Forward: Vy=1000, Vx=0, omega=0, r=10 -> v1=100, v2=-50, v3=-50.
REQ-031 Lateral floor/truncation: Vx=1000, r=1, others 0 -> (0, -866, 866); Vx=-1000 -> (0, 867, -867).
REQ-032 Overflow: R=65535, omega=32767, r=1, Vx=Vy=0 -> with IK_SATURATE_EN all wheels 32767, ovf=1; without it all wheels -32767, ovf=0.
REQ-033 Divide by zero: r=0, Vy=5, Vx=0, omega=0 -> v1=32767, v2=-32768, v3=-32768, div_zero=1, done at E+106.
REQ-034 Reset mid-job: rst pulsed at E+50 -> all outputs 0, busy=0, no done. A new start with the REQ-029 inputs then gives 20, 20, 20.

Source files
------------

// File: rtl/inverse_kinematics_omni.sv
// Inverse kinematics for a three-wheel omni base: body velocity (Vx, Vy, omega)
// to wheel rates v1..v3, using one shared multiplier and one serial divider.
// Optional feature: define IK_SATURATE_EN to clamp out-of-range wheel rates and
// report them on ovf. Without it, results wrap to 16 bits and ovf stays 0.
module inverse_kinematics_omni #(
  parameter int unsigned K_SQRT3_2 = 28378
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] Vx,
  input  logic signed [15:0] Vy,
  input  logic signed [15:0] omega,
  input  logic        [15:0] r,
  input  logic        [15:0] R,
  output logic signed [15:0] v1,
  output logic signed [15:0] v2,
  output logic signed [15:0] v3,
  output logic               done,
  output logic               busy,
  output logic               div_zero,
  output logic               ovf
);

  localparam logic [15:0] KQ = K_SQRT3_2[15:0];

  typedef enum logic [2:0] {StIdle, StMulR, StMulS, StSum, StDiv, StDone} state_e;

  state_e state_q, state_d;

  logic signed [15:0] vx_q, vy_q, om_q, hy_q;
  logic        [15:0] rr_q, bigr_q;
  logic signed [31:0] rw_q;
  logic signed [16:0] sx_q;
  logic signed [33:0] u1_q, u2_q, u3_q;
  logic        [15:0] rem_q;
  logic        [33:0] q_q;
  logic        [5:0]  bit_q;
  logic        [1:0]  wheel_q;
  logic signed [15:0] res1_q, res2_q, res3_q;
  logic               ovf_acc_q;

  logic signed [16:0] mul_a, mul_b;
  logic signed [33:0] prod;
  logic signed [33:0] vy_e, rw_e, sx_e, hy_e;
  logic signed [33:0] u_sel;
  logic               neg;
  logic        [33:0] mag, dvd, q_nx, sq;
  logic        [15:0] rem_in, rem_nx;
  logic        [16:0] trial;
  logic               ge;
  logic signed [15:0] res_val;
  logic               res_ovf;

  // Next-state logic for the job sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StMulR;
      StMulR: state_d = StMulS;
      StMulS: state_d = StSum;
      StSum:  state_d = StDiv;
      StDiv:  if (bit_q == 6'd33 && wheel_q == 2'd2) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Shared multiplier plus sign extension of the summands
  always_comb begin
    mul_a = (state_q == StMulS) ? signed'({1'b0, KQ}) : signed'({1'b0, bigr_q});
    mul_b = (state_q == StMulS) ? {vx_q[15], vx_q} : {om_q[15], om_q};
    prod  = mul_a * mul_b;
    vy_e  = {{18{vy_q[15]}}, vy_q};
    rw_e  = {{2{rw_q[31]}}, rw_q};
    sx_e  = {{17{sx_q[16]}}, sx_q};
    hy_e  = {{18{hy_q[15]}}, hy_q};
  end

  // One restoring-divider step on |u| of the current wheel, plus result shaping
  always_comb begin
    unique case (wheel_q)
      2'd0:    u_sel = u1_q;
      2'd1:    u_sel = u2_q;
      default: u_sel = u3_q;
    endcase
    neg    = u_sel[33];
    mag    = neg ? 34'(-u_sel) : 34'(u_sel);
    dvd    = (bit_q == 6'd0) ? mag : q_q;
    rem_in = (bit_q == 6'd0) ? 16'd0 : rem_q;
    trial  = {rem_in, dvd[33]};
    ge     = trial >= {1'b0, rr_q};
    rem_nx = ge ? 16'(trial - {1'b0, rr_q}) : trial[15:0];
    q_nx   = {dvd[32:0], ge};
    sq     = neg ? -q_nx : q_nx;
    res_ovf = 1'b0;
    res_val = sq[15:0];
`ifdef IK_SATURATE_EN
    if (!neg && q_nx > 34'd32767) begin
      res_val = 16'sh7fff;
      res_ovf = 1'b1;
    end else if (neg && q_nx > 34'd32768) begin
      res_val = 16'sh8000;
      res_ovf = 1'b1;
    end
`endif
    // Zero radius: report only the direction, at full scale
    if (rr_q == 16'd0) begin
      res_ovf = 1'b0;
      if (u_sel == 34'sd0) res_val = 16'sd0;
      else if (neg)        res_val = 16'sh8000;
      else                 res_val = 16'sh7fff;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx_q <= '0; vy_q <= '0; om_q <= '0; rr_q <= '0; bigr_q <= '0;
      rw_q <= '0; sx_q <= '0; hy_q <= '0;
      u1_q <= '0; u2_q <= '0; u3_q <= '0;
      rem_q <= '0; q_q <= '0; bit_q <= '0; wheel_q <= '0;
      res1_q <= '0; res2_q <= '0; res3_q <= '0; ovf_acc_q <= 1'b0;
      v1 <= '0; v2 <= '0; v3 <= '0;
      done <= 1'b0; busy <= 1'b0; div_zero <= 1'b0; ovf <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done      <= 1'b0;
          busy      <= start;
          bit_q     <= '0;
          wheel_q   <= '0;
          ovf_acc_q <= 1'b0;
          if (start) begin
            vx_q <= Vx; vy_q <= Vy; om_q <= omega; rr_q <= r; bigr_q <= R;
          end
        end
        StMulR: rw_q <= prod[31:0];
        StMulS: begin
          sx_q <= prod[31:15];
          hy_q <= vy_q >>> 1;
        end
        StSum: begin
          u1_q <= vy_e + rw_e;
          u2_q <= -sx_e - hy_e + rw_e;
          u3_q <= sx_e - hy_e + rw_e;
        end
        StDiv: begin
          rem_q <= rem_nx;
          q_q   <= q_nx;
          if (bit_q == 6'd33) begin
            bit_q     <= '0;
            wheel_q   <= wheel_q + 2'd1;
            ovf_acc_q <= ovf_acc_q | res_ovf;
            unique case (wheel_q)
              2'd0:    res1_q <= res_val;
              2'd1:    res2_q <= res_val;
              default: res3_q <= res_val;
            endcase
          end else begin
            bit_q <= bit_q + 6'd1;
          end
        end
        StDone: begin
          v1       <= res1_q;
          v2       <= res2_q;
          v3       <= res3_q;
          div_zero <= (rr_q == 16'd0);
          ovf      <= ovf_acc_q;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_kinematics_omni.sv
// Scoreboard bench for inverse_kinematics_omni: directed jobs push expected
// wheel rates and done cycle; a negedge monitor pops and compares on done.
module tb_inverse_kinematics_omni;

  logic clk = 1'b0;
  logic rst, start;
  logic signed [15:0] Vx, Vy, omega;
  logic        [15:0] r, R;
  logic signed [15:0] v1, v2, v3;
  logic done, busy, div_zero, ovf;

  inverse_kinematics_omni dut (
    .clk(clk), .rst(rst), .start(start), .Vx(Vx), .Vy(Vy), .omega(omega),
    .r(r), .R(R), .v1(v1), .v2(v2), .v3(v3), .done(done), .busy(busy),
    .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int e1; int e2; int e3; int dz; int ov; int at;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("v1", int'(v1), e.e1);
        chk("v2", int'(v2), e.e2);
        chk("v3", int'(v3), e.e3);
        chk("div_zero", int'(div_zero), e.dz);
        chk("ovf", int'(ovf), e.ov);
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic run_job(input int vx, input int vy, input int om, input int rr, input int bigr,
                         input int e1, input int e2, input int e3, input int dz, input int ov);
    int n;
    exp_t e;
    @(negedge clk);
    Vx = 16'(vx); Vy = 16'(vy); omega = 16'(om); r = 16'(rr); R = 16'(bigr);
    start = 1'b1;
    e = '{e1: e1, e2: e2, e3: e3, dz: dz, ov: ov, at: cyc + 107};
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    // Inputs change after acceptance; they must not affect the job
    Vx = 16'($urandom); Vy = 16'($urandom); omega = 16'($urandom);
    r = 16'($urandom); R = 16'($urandom);
    repeat (20) @(negedge clk);
    start = 1'b1;  // ignored while busy
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
      sb.delete();
    end
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    Vx = '0; Vy = '0; omega = '0; r = '0; R = '0;
    repeat (3) @(negedge clk);
    chk("rst_v1", int'(v1), 0);
    chk("rst_v2", int'(v2), 0);
    chk("rst_v3", int'(v3), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flags", int'({div_zero, ovf}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_job(0, 0, 10, 100, 200, 20, 20, 20, 0, 0);        // pure rotation
    run_job(0, 1000, 0, 10, 0, 100, -50, -50, 0, 0);      // forward
    run_job(1000, 0, 0, 1, 0, 0, -866, 866, 0, 0);        // lateral +
    run_job(-1000, 0, 0, 1, 0, 0, 867, -867, 0, 0);       // lateral -, floor
`ifdef IK_SATURATE_EN
    run_job(0, 0, 32767, 1, 65535, 32767, 32767, 32767, 0, 1);
`else
    run_job(0, 0, 32767, 1, 65535, -32767, -32767, -32767, 0, 0);
`endif
    run_job(0, 5, 0, 0, 0, 32767, -32768, -32768, 1, 0);  // r == 0
    run_job(0, 0, -10, 100, 200, -20, -20, -20, 0, 0);    // flags clear again

    // Reset in the middle of a job
    @(negedge clk);
    Vx = 16'sd0; Vy = 16'sd0; omega = 16'sd10; r = 16'd100; R = 16'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (48) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_v1", int'(v1), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    chk("after_rst_busy", int'(busy), 0);
    chk("after_rst_v2", int'(v2), 0);
    chk("after_rst_v3", int'(v3), 0);
    chk("after_rst_flags", int'({div_zero, ovf, done}), 0);

    run_job(0, 0, 10, 100, 200, 20, 20, 20, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
